// File: rtl/pkt_defs.sv
// Shared packet framing definitions for the fifo packet reader and writer.
package pkt_defs;

   // Reader FSM encoding, fixed so both sides of the router agree on it
   typedef enum logic [1:0] {
      HEADER  = 2'd0,
      PAYLOAD = 2'd1,
      HOLD    = 2'd2
   } pkt_state_e;

   // Position of the payload length field inside a header flit
   localparam int unsigned LEN_FIELD_LSB = 0;

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Mid-packet idle counter: counts consecutive idle cycles and flags expiry.
// Only instantiated when PKT_READER_TIMEOUT_EN is defined.
module pkt_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic idle,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   // Count idle cycles; any clear restarts the window
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (idle) begin
         count <= count + 1'b1;
      end
   end

   // Expiry fires on the idle cycle that completes the window
   assign expired = idle && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fifo_packet_reader.sv
// Consumer end of the router input fifo: deframes header+payload packets and
// holds each one as a wide word until the core accepts it.
// Optional mid-packet timeout abort: define PKT_READER_TIMEOUT_EN.
module fifo_packet_reader
   import pkt_defs::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_BITS       = 3,
   parameter int unsigned MAX_PAYLOAD    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              reset,
   output logic                              fifo_rd_en,
   output logic                              fifo_peek,
   input  logic [DATA_WIDTH-1:0]             fifo_data,
   input  logic                              fifo_valid,
   input  logic                              fifo_empty,
   output logic                              pkt_valid,
   input  logic                              pkt_ready,
   output logic [DATA_WIDTH-1:0]             pkt_header,
   output logic [LEN_BITS-1:0]               pkt_len,
   output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] pkt_data,
   output logic                              pkt_err
);

   localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_PAYLOAD);

   pkt_state_e          state;
   pkt_state_e          state_next;
   logic [LEN_BITS-1:0] len;
   logic [LEN_BITS-1:0] cnt;
   logic [LEN_BITS-1:0] hdr_len;
   logic                last_word;
   logic                expired;
   logic                unused_empty;

   assign hdr_len   = fifo_data[LEN_FIELD_LSB +: LEN_BITS];
   assign last_word = fifo_valid && (cnt == len - 1'b1);

   // fifo_empty is status only; rd_en must not depend on it (empty is combinational on rdEn)
   assign unused_empty = fifo_empty;

`ifdef PKT_READER_TIMEOUT_EN
   logic in_payload;
   assign in_payload = (state == PAYLOAD);

   pkt_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (!in_payload || fifo_valid),
      .idle    (in_payload && !fifo_valid),
      .expired (expired)
   );
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif

   // Pop request and packet-valid are pure state decodes
   assign fifo_rd_en = ((state == HEADER) || (state == PAYLOAD)) && !reset;
   assign fifo_peek  = 1'b0;
   assign pkt_valid  = (state == HOLD);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= HEADER;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         HEADER: begin
            if (fifo_valid) begin
               state_next = (hdr_len == '0) ? HOLD : PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (last_word || expired) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (pkt_ready) begin
               state_next = HEADER;
            end
         end
         default: state_next = HEADER;
      endcase
   end

   // Header capture, payload storage and completion status
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_header <= '0;
         pkt_len    <= '0;
         pkt_data   <= '0;
         pkt_err    <= 1'b0;
         len        <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            HEADER: begin
               if (fifo_valid) begin
                  pkt_header <= fifo_data;
                  len        <= hdr_len;
                  cnt        <= '0;
                  pkt_err    <= 1'b0;
                  if (hdr_len == '0) begin
                     pkt_len <= '0;
                  end
               end
            end
            PAYLOAD: begin
               if (fifo_valid) begin
                  // Words beyond MAX_PAYLOAD match no slot and are drained without storing
                  for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
                     if (cnt == LEN_BITS'(k)) begin
                        pkt_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
                     end
                  end
                  cnt <= cnt + 1'b1;
                  if (last_word) begin
                     pkt_len <= (len > MAX_LEN) ? MAX_LEN : len;
                     pkt_err <= (len > MAX_LEN);
                  end
               end else if (expired) begin
                  pkt_len <= (cnt > MAX_LEN) ? MAX_LEN : cnt;
                  pkt_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Self-checking bench for fifo_packet_reader: scoreboard of expected packets,
// one task per scenario.
module tb_fifo_packet_reader;

   localparam int unsigned DW      = 32;
   localparam int unsigned LB      = 3;
   localparam int unsigned MAXP    = 4;
   localparam int unsigned TIMEOUT = 64;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            fifo_rd_en;
   logic            fifo_peek;
   logic [DW-1:0]   fifo_data = '0;
   logic            fifo_valid = 1'b0;
   logic            fifo_empty = 1'b1;
   logic            pkt_valid;
   logic            pkt_ready = 1'b0;
   logic [DW-1:0]   pkt_header;
   logic [LB-1:0]   pkt_len;
   logic [MAXP*DW-1:0] pkt_data;
   logic            pkt_err;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   typedef struct {
      logic [DW-1:0] header;
      logic [LB-1:0] len;
      logic          err;
      logic [DW-1:0] data [MAXP];
   } exp_t;

   exp_t sb[$];

   fifo_packet_reader #(
      .DATA_WIDTH     (DW),
      .LEN_BITS       (LB),
      .MAX_PAYLOAD    (MAXP),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_rd_en (fifo_rd_en),
      .fifo_peek  (fifo_peek),
      .fifo_data  (fifo_data),
      .fifo_valid (fifo_valid),
      .fifo_empty (fifo_empty),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .pkt_header (pkt_header),
      .pkt_len    (pkt_len),
      .pkt_data   (pkt_data),
      .pkt_err    (pkt_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] word_of(input logic [DW-1:0] hdr, input int unsigned k);
      return hdr ^ (32'h1000_0000 * (k + 1)) ^ 32'h0000_0A50;
   endfunction

   // Expected result of a full packet: kept words capped at MAXP, err on overflow
   function automatic exp_t model_pkt(input logic [DW-1:0] hdr);
      exp_t e;
      int unsigned n;
      n = int'(hdr[LB-1:0]);
      e.header = hdr;
      e.len    = LB'((n > MAXP) ? MAXP : n);
      e.err    = (n > MAXP);
      for (int unsigned k = 0; k < MAXP; k++) e.data[k] = word_of(hdr, k);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word, only while the reader is requesting (as the fifo would)
   task automatic send_word(input logic [DW-1:0] w);
      int unsigned n = 0;
      while (fifo_rd_en !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests_run++;
      if (fifo_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL rd_en_wait: fifo_rd_en=%b required 1 before word %h", fifo_rd_en, w);
      end else begin
         fifo_valid = 1'b1;
         fifo_empty = 1'b0;
         fifo_data  = w;
         step();
         fifo_valid = 1'b0;
         fifo_empty = 1'b1;
      end
   endtask

   task automatic send_packet(input logic [DW-1:0] hdr, input int unsigned gap);
      sb.push_back(model_pkt(hdr));
      send_word(hdr);
      for (int unsigned k = 0; k < int'(hdr[LB-1:0]); k++) begin
         if (k != 0) begin
            for (int unsigned g = 0; g < gap; g++) begin
               step();
               tests_run++;
               if (pkt_valid !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL gap_valid: pkt_valid=%b required 0", pkt_valid);
               end
            end
         end
         send_word(word_of(hdr, k));
      end
   endtask

   task automatic check_pkt(input string name);
      int unsigned n = 0;
      exp_t e;
      while (pkt_valid !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      tests_run++;
      if (pkt_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_valid: pkt_valid=%b required 1", name, pkt_valid);
      end
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $display("FAIL %s_scoreboard: queue size 0 required >0", name);
         return;
      end
      e = sb.pop_front();
      tests_run += 3;
      if (pkt_header !== e.header) begin
         tests_failed++;
         $display("FAIL %s_header: got %h required %h", name, pkt_header, e.header);
      end
      if (pkt_len !== e.len) begin
         tests_failed++;
         $display("FAIL %s_len: got %0d required %0d", name, pkt_len, e.len);
      end
      if (pkt_err !== e.err) begin
         tests_failed++;
         $display("FAIL %s_err: got %b required %b", name, pkt_err, e.err);
      end
      for (int unsigned k = 0; k < int'(e.len); k++) begin
         tests_run++;
         if (pkt_data[k*DW +: DW] !== e.data[k]) begin
            tests_failed++;
            $display("FAIL %s_data%0d: got %h required %h", name, k, pkt_data[k*DW +: DW], e.data[k]);
         end
      end
   endtask

   task automatic accept(input string name);
      pkt_ready = 1'b1;
      step();
      pkt_ready = 1'b0;
      tests_run++;
      if (pkt_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_accept: valid=%b rd_en=%b required valid=0 rd_en=1", name, pkt_valid, fifo_rd_en);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      tests_run++;
      if (fifo_rd_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en);
      end
      step();
      reset = 1'b0;
      #1;
      tests_run++;
      if (pkt_valid !== 1'b0 || pkt_err !== 1'b0 || pkt_len !== '0 || pkt_header !== '0 ||
          pkt_data !== '0 || fifo_peek !== 1'b0 || fifo_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_state: valid=%b err=%b len=%0d hdr=%h data=%h peek=%b rd_en=%b required 0,0,0,0,0,0,1",
                  pkt_valid, pkt_err, pkt_len, pkt_header, pkt_data, fifo_peek, fifo_rd_en);
      end
   endtask

   task automatic test_basic();
      int c0;
      c0 = cyc;
      send_packet(32'hA0B0_C003, 0);
      tests_run++;
      if (pkt_valid !== 1'b1 || (cyc - c0) != 4) begin
         tests_failed++;
         $display("FAIL basic_latency: valid=%b after %0d edges required valid=1 after 4", pkt_valid, cyc - c0);
      end
      check_pkt("basic");
      accept("basic");
   endtask

   task automatic test_zero_len();
      send_packet(32'h0000_7770, 0);
      for (int unsigned i = 0; i < 5; i++) begin
         tests_run++;
         if (pkt_valid !== 1'b1 || fifo_rd_en !== 1'b0 || pkt_header !== 32'h0000_7770 || pkt_len !== '0) begin
            tests_failed++;
            $display("FAIL zero_hold: valid=%b rd_en=%b hdr=%h len=%0d required 1,0,00007770,0",
                     pkt_valid, fifo_rd_en, pkt_header, pkt_len);
         end
         step();
      end
      check_pkt("zero");
      accept("zero");
   endtask

   task automatic test_overflow();
      send_packet(32'hBEEF_0006, 0);
      check_pkt("ovf");
      accept("ovf");
      send_packet(32'hC0DE_0001, 0);
      check_pkt("after_ovf");
      accept("after_ovf");
   endtask

   task automatic test_gaps();
      send_packet(32'h9ABC_0003, 3);
      check_pkt("gaps");
      accept("gaps");
   endtask

   task automatic test_reset_mid();
      send_word(32'h5555_0003);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      reset = 1'b1;
      #1;
      tests_run++;
      if (fifo_rd_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_rd_en: got %b required 0", fifo_rd_en);
      end
      step();
      reset = 1'b0;
      #1;
      tests_run++;
      if (pkt_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_state: valid=%b rd_en=%b required 0,1", pkt_valid, fifo_rd_en);
      end
      send_packet(32'h6666_0001, 0);
      check_pkt("midreset");
      accept("midreset");
   endtask

   task automatic test_timeout();
      exp_t e;
      logic [DW-1:0] hdr;
      hdr = 32'h7777_0003;
      e = model_pkt(hdr);
`ifdef PKT_READER_TIMEOUT_EN
      int unsigned n = 0;
      e.len = 3'd1;
      e.err = 1'b1;
      sb.push_back(e);
      send_word(hdr);
      send_word(word_of(hdr, 0));
      while (pkt_valid !== 1'b1 && n < TIMEOUT + 20) begin
         step();
         n++;
      end
      tests_run++;
      if (n != TIMEOUT) begin
         tests_failed++;
         $display("FAIL timeout_cycles: got %0d required %0d", n, TIMEOUT);
      end
      check_pkt("timeout");
      accept("timeout");
`else
      sb.push_back(e);
      send_word(hdr);
      send_word(word_of(hdr, 0));
      for (int unsigned i = 0; i < TIMEOUT + 6; i++) step();
      tests_run++;
      if (pkt_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL no_timeout: valid=%b rd_en=%b required 0,1", pkt_valid, fifo_rd_en);
      end
      send_word(word_of(hdr, 1));
      send_word(word_of(hdr, 2));
      check_pkt("no_timeout");
      accept("no_timeout");
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_overflow();
      test_gaps();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
